// File: rtl/digpot_pkg.sv
// Shared constants for the digital-potentiometer sequencer: FSM encoding,
// direction values and the default tap count.
package digpot_pkg;
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_INC_LO = 3'd2;
    localparam logic [2:0] S_INC_HI = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    localparam int STEPS_DEF = 100;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
endpackage

// File: rtl/digpot_tick.sv
// Loadable down-counter; tc is high while the count sits at zero, so a load of
// L-1 on state entry makes that state last exactly L cycles.
module digpot_tick
    import digpot_pkg::*;
#(
    parameter int W       = 3,
    parameter int RST_VAL = 0
) (
    input  logic         clk_in,
    input  logic         reset,
    input  logic         ld,
    input  logic [W-1:0] val,
    output logic         tc
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset)
            cnt <= W'(RST_VAL);
        else if (ld)
            cnt <= val;
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end

    assign tc = (cnt == '0);
endmodule

// File: rtl/digpot_seq.sv
// Three-wire up/down digital-pot sequencer: converts an absolute tap target
// into a burst of INC pulses, tracks the wiper and homes to tap 0 after reset.
module digpot_seq
    import digpot_pkg::*;
#(
    parameter int STEPS = STEPS_DEF,
    parameter int DIV   = 4,
    parameter int SETUP = 2,
    parameter int HOLD  = 2
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic [6:0] target,
    input  logic       load,
    input  logic       home,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [6:0] wiper,
    output logic       dp_cs_n,
    output logic       dp_ud,
    output logic       dp_inc_n
);
    localparam int TMAX = max3(DIV, SETUP, HOLD);
    localparam int CW   = $clog2(TMAX + 1);

    logic [2:0]    state, nxt;
    logic          dir, dir_nxt;
    logic          homing;
    logic [6:0]    pulses;
    logic          tick_ld, tc, load_ok;
    logic [CW-1:0] tick_val;

    assign load_ok = load && (target <= 7'(STEPS - 1));

    // Reset parks the counter at SETUP (not SETUP-1): CS only goes low on the
    // first clock, so one extra cycle keeps the full setup time.
    digpot_tick #(.W(CW), .RST_VAL(SETUP)) u_tick (
        .clk_in (clk_in),
        .reset  (reset),
        .ld     (tick_ld),
        .val    (tick_val),
        .tc     (tc)
    );

    always_comb begin
        nxt     = state;
        dir_nxt = dir;
        case (state)
            S_IDLE: begin
                if (home) begin
                    nxt     = S_SETUP;
                    dir_nxt = DOWN;
                end else if (load_ok && target != wiper) begin
                    nxt     = S_SETUP;
                    dir_nxt = (target > wiper) ? UP : DOWN;
                end
            end
            S_SETUP:  if (tc) nxt = S_INC_LO;
            S_INC_LO: if (tc) nxt = S_INC_HI;
            S_INC_HI: if (tc) nxt = (pulses != '0) ? S_INC_LO : S_HOLD;
            S_HOLD:   if (tc) nxt = S_FIN;
            S_FIN:    nxt = S_IDLE;
            default:  nxt = S_IDLE;
        endcase
    end

    always_comb begin
        tick_ld  = (nxt != state);
        tick_val = '0;
        case (nxt)
            S_SETUP:           tick_val = CW'(SETUP - 1);
            S_INC_LO, S_INC_HI: tick_val = CW'(DIV - 1);
            S_HOLD:            tick_val = CW'(HOLD - 1);
            default:           tick_val = '0;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state    <= S_SETUP;
            dir      <= DOWN;
            homing   <= 1'b1;
            pulses   <= 7'(STEPS);
            wiper    <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            dp_cs_n  <= 1'b1;
            dp_inc_n <= 1'b1;
            dp_ud    <= 1'b0;
        end else begin
            state <= nxt;
            dir   <= dir_nxt;
            done  <= 1'b0;
            err   <= 1'b0;
            // Requests outside IDLE are dropped silently; home beats load.
            if (state == S_IDLE) begin
                if (home) begin
                    homing <= 1'b1;
                    pulses <= 7'(STEPS);
                end else if (load) begin
                    if (!load_ok)
                        err <= 1'b1;
                    else if (target == wiper)
                        done <= 1'b1;
                    else begin
                        homing <= 1'b0;
                        pulses <= (target > wiper) ? target - wiper : wiper - target;
                    end
                end
            end
            // The device steps on the INC falling edge, so track it there.
            if (nxt == S_INC_LO && state != S_INC_LO) begin
                pulses <= pulses - 7'd1;
                if (!homing)
                    wiper <= (dir == UP) ? wiper + 7'd1 : wiper - 7'd1;
            end
            if (nxt == S_FIN) begin
                done <= 1'b1;
                if (homing)
                    wiper <= '0;
            end
            busy     <= (nxt != S_IDLE) && (nxt != S_FIN);
            dp_cs_n  <= (nxt == S_IDLE) || (nxt == S_FIN);
            dp_inc_n <= (nxt != S_INC_LO);
            dp_ud    <= dir_nxt;
        end
    end
endmodule

// File: tb/tb_digpot_seq.sv
// Randomized bench for digpot_seq: a pin-level monitor counts INC pulses and
// CS activity, and each operation is compared against arithmetic expectations.
module tb_digpot_seq;
    localparam int STEPS = 100;
    localparam int DIV   = 4;
    localparam int SETUP = 2;
    localparam int HOLD  = 2;

    logic       clk_in = 1'b0;
    logic       reset  = 1'b0;
    logic       load   = 1'b0;
    logic       home   = 1'b0;
    logic [6:0] target = '0;
    logic       busy, done, err, dp_cs_n, dp_ud, dp_inc_n;
    logic [6:0] wiper;

    digpot_seq #(.STEPS(STEPS), .DIV(DIV), .SETUP(SETUP), .HOLD(HOLD)) dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .target   (target),
        .load     (load),
        .home     (home),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .wiper    (wiper),
        .dp_cs_n  (dp_cs_n),
        .dp_ud    (dp_ud),
        .dp_inc_n (dp_inc_n)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Pin monitor: owns all its counters; the main thread only snapshots them.
    logic exp_ud = 1'b0;
    int   cyc = 0, falls = 0, lo_cycles = 0, cs_falls = 0, ud_bad = 0, cs_bad = 0;
    int   t_cs_fall = 0, setup_len = -1;
    bit   first_pend = 1'b0;
    logic inc_p = 1'b1, cs_p = 1'b1;

    always @(negedge clk_in) begin
        cyc++;
        if (reset) begin
            if (cs_p && !dp_cs_n) begin
                cs_falls++;
                t_cs_fall  = cyc;
                first_pend = 1'b1;
            end
            if (inc_p && !dp_inc_n) begin
                falls++;
                if (dp_ud !== exp_ud) ud_bad++;
                if (dp_cs_n !== 1'b0) cs_bad++;
                if (first_pend) begin
                    setup_len  = cyc - t_cs_fall;
                    first_pend = 1'b0;
                end
            end
            if (!dp_inc_n) lo_cycles++;
        end
        inc_p = dp_inc_n;
        cs_p  = dp_cs_n;
    end

    int m_wiper = 0;

    function automatic int move_lat(input int n);
        return (n == 0) ? 2 : 1 + SETUP + 2 * DIV * n + HOLD + 1;
    endfunction

    task automatic start_req(input int t, input logic ld, input logic hm);
        @(negedge clk_in);
        target = 7'(t);
        load   = ld;
        home   = hm;
        @(posedge clk_in);
        #1;
        load = 1'b0;
        home = 1'b0;
    endtask

    // lat counts cycles inclusively from the request cycle to the done/err cycle.
    task automatic wait_done(input int budget, output int lat, output bit saw_err,
                             output bit busy1);
        lat = 1; saw_err = 1'b0; busy1 = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_in);
            lat++;
            if (i == 0) busy1 = busy;
            if (err) saw_err = 1'b1;
            if (done || err) return;
        end
        lat = -1;
    endtask

    task automatic do_move(input int t);
        int f0, l0, c0, u0, b0, lat, n;
        bit e, b1, bad;
        bad    = (t > STEPS - 1);
        n      = bad ? 0 : ((t > m_wiper) ? t - m_wiper : m_wiper - t);
        exp_ud = (t > m_wiper);
        f0 = falls; l0 = lo_cycles; c0 = cs_falls; u0 = ud_bad; b0 = cs_bad;
        start_req(t, 1'b1, 1'b0);
        wait_done(3000, lat, e, b1);
        chk($sformatf("lat_t%0d", t), lat, bad ? 2 : move_lat(n));
        chk($sformatf("err_t%0d", t), int'(e), int'(bad));
        chk($sformatf("busy_t%0d", t), int'(b1), int'(n != 0));
        chk($sformatf("pulses_t%0d", t), falls - f0, n);
        chk($sformatf("lowcyc_t%0d", t), lo_cycles - l0, DIV * n);
        chk($sformatf("csfall_t%0d", t), cs_falls - c0, (n != 0) ? 1 : 0);
        chk($sformatf("ud_t%0d", t), ud_bad - u0, 0);
        chk($sformatf("cs_low_t%0d", t), cs_bad - b0, 0);
        if (n != 0) chk($sformatf("setup_t%0d", t), setup_len, SETUP);
        if (!bad) m_wiper = t;
        chk($sformatf("wiper_t%0d", t), int'(wiper), m_wiper);
        @(negedge clk_in);
        chk($sformatf("pulse1_t%0d", t), int'(done | err), 0);
    endtask

    task automatic check_home(input string tag, input int f0, input int lat_exp,
                              input int lat);
        chk({tag, "_pulses"}, falls - f0, STEPS);
        chk({tag, "_wiper"}, int'(wiper), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        if (lat_exp > 0) chk({tag, "_lat"}, lat, lat_exp);
        m_wiper = 0;
    endtask

    initial begin
        int f0, u0, lat, t;
        bit e, b1, hit;
        exp_ud = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_cs_n", int'(dp_cs_n), 1);
        chk("rst_inc_n", int'(dp_inc_n), 1);
        chk("rst_ud", int'(dp_ud), 0);
        chk("rst_done_err", int'(done | err), 0);
        chk("rst_wiper", int'(wiper), 0);
        chk("rst_busy", int'(busy), 1);

        // Power-up homing with no request.
        f0 = falls; u0 = ud_bad;
        @(negedge clk_in);
        reset = 1'b1;
        wait_done(3000, lat, e, b1);
        check_home("boot", f0, move_lat(STEPS), lat);
        chk("boot_ud", ud_bad - u0, 0);
        chk("boot_setup", setup_len, SETUP);

        do_move(5);
        do_move(2);
        do_move(2);
        do_move(100);

        for (int k = 0; k < 8; k++) begin
            t = ($urandom_range(0, 4) == 0) ? int'($urandom_range(100, 127))
                                            : int'($urandom_range(0, STEPS - 1));
            do_move(t);
        end

        // Requests while busy are ignored.
        do_move(0);
        exp_ud = 1'b1;
        f0 = falls;
        start_req(50, 1'b1, 1'b0);
        repeat (30) @(negedge clk_in);
        target = 7'd10; load = 1'b1; home = 1'b1;
        @(posedge clk_in);
        #1;
        load = 1'b0; home = 1'b0;
        wait_done(3000, lat, e, b1);
        chk("busy_ign_err", int'(e), 0);
        chk("busy_ign_pulses", falls - f0, 50);
        chk("busy_ign_wiper", int'(wiper), 50);
        m_wiper = 50;

        // home and load together: home wins, no err.
        exp_ud = 1'b0;
        f0 = falls; u0 = ud_bad;
        start_req(70, 1'b1, 1'b1);
        wait_done(3000, lat, e, b1);
        chk("home_ld_err", int'(e), 0);
        chk("home_ld_ud", ud_bad - u0, 0);
        check_home("home_ld", f0, move_lat(STEPS), lat);

        // Reset in the middle of a burst.
        do_move(37);
        exp_ud = 1'b0;
        f0 = falls;
        start_req(0, 1'b1, 1'b0);
        hit = 1'b0;
        for (int i = 0; i < 2000 && !hit; i++) begin
            @(negedge clk_in);
            if (falls - f0 >= 20) hit = 1'b1;
        end
        chk("midrst_reached20", int'(hit), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_cs_n", int'(dp_cs_n), 1);
        chk("midrst_inc_n", int'(dp_inc_n), 1);
        chk("midrst_busy", int'(busy), 1);
        repeat (2) @(posedge clk_in);
        f0 = falls;
        @(negedge clk_in);
        reset = 1'b1;
        wait_done(3000, lat, e, b1);
        check_home("rehome", f0, move_lat(STEPS), lat);

        do_move(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/digpot_seq.md
Name: digpot_seq

Overview:
- Sequencer for a three-wire up/down digital potentiometer with chip-select, up/down and increment inputs, 100 taps.
- Takes an absolute 7-bit wiper target from the host/Wishbone register side and issues the signed number of INC pulses, with CS/UD setup and hold timing.
- Tracks the wiper position internally.
- Homes the wiper to tap 0 after reset or on request, because the device position is unknown at power-up.

Parameters:
- STEPS, 100, number of taps; valid positions 0..STEPS-1.
- DIV, 4, clk_in cycles per INC half-period (INC low DIV cycles, then high DIV cycles).
- SETUP, 2, clk_in cycles from CS low / UD valid to the first INC falling edge.
- HOLD, 2, clk_in cycles from the last INC rising edge to CS high.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- target  input  7  requested wiper position; sampled when load=1.
- load  input  1  single-cycle move request.
- home  input  1  single-cycle re-home request.
- busy  output  1  high while a home or move is in progress.
- done  output  1  one-cycle pulse when a home or move completes.
- err  output  1  one-cycle pulse when a load is rejected.
- wiper  output  7  tracked wiper position.
- dp_cs_n  output  1  device chip select, active-low.
- dp_ud  output  1  direction; 1=up, 0=down.
- dp_inc_n  output  1  device increment; wiper steps on its falling edge.

Behaviour:
- Reset (reset=0, asynchronous), all outputs and registers:
  - dp_cs_n=1, dp_inc_n=1, dp_ud=0, done=0, err=0, wiper=0, busy=1.
  - state=SETUP with a pending home: dir=down, pulse count=STEPS.
  - After reset is released, homing starts on the next clock without any request.
- States:
  - IDLE
  - SETUP: dp_cs_n=0, dp_ud=dir; wait SETUP cycles.
  - INC_LO: dp_inc_n=0 for DIV cycles.
  - INC_HI: dp_inc_n=1 for DIV cycles.
  - HOLD: dp_inc_n=1, dp_cs_n=0 for HOLD cycles.
  - FIN: dp_cs_n=1; done=1 for one cycle; busy=0; next state IDLE.
- Transitions:
  - SETUP -> INC_LO.
  - INC_LO -> INC_HI.
  - INC_HI -> INC_LO while the pulse count remaining is >0 after decrement; otherwise -> HOLD.
  - HOLD -> FIN.
- Wiper and pulse accounting:
  - wiper updates by ±1 on each entry to INC_LO (the device falling edge). Homing does not change wiper until FIN; FIN then forces wiper=0.
  - During homing the pulse count is STEPS, which guarantees the wiper reaches tap 0 from any position. Extra down pulses at tap 0 saturate in the device and are harmless.
- IDLE with load=1:
  - target > STEPS-1: err=1 for one cycle; no bus activity; stay IDLE.
  - target == wiper: done=1 next cycle; busy stays 0; no CS or INC activity.
  - target > wiper: dir=1, count=target-wiper, busy=1, go to SETUP.
  - target < wiper: dir=0, count=wiper-target, busy=1, go to SETUP.
  - busy rises the cycle after load.
- home in IDLE: dir=0, count=STEPS, busy=1, go to SETUP.
- home and load in the same cycle: home wins; load is dropped with no err.
- load or home while busy=1: ignored with no err; the host must wait for done.
- Latency for a move of N steps, from load to done: 1 + SETUP + 2·DIV·N + HOLD + 1 cycles.
- Arithmetic: delta is a 7-bit unsigned subtraction of the smaller from the larger, so there is no wrap. The counter range is 0..STEPS.
- Cycle counter: one shared down-counter, reloaded at each state entry, sized to max(DIV, SETUP, HOLD).
- Reset mid-operation: outputs return immediately to their reset values (CS released asynchronously, INC high), then a full re-home runs.
- All device outputs are registered; there is no clock gating and no glitching on dp_inc_n.

Decomposition:
- Shared package: state encoding localparams (IDLE, SETUP, INC_LO, INC_HI, HOLD, FIN), UP=1/DOWN=0 constants, and the STEPS default.
- One sub-module, digpot_tick: a loadable down-counter with a terminal-count output, used for SETUP, DIV and HOLD timing.
- The FSM and the wiper tracker stay in digpot_seq.

Test Plan:
- Release reset: dp_cs_n falls, then 100 dp_inc_n low pulses each 4 cycles wide with dp_ud=0. dp_cs_n rises 2 cycles after the last rise; done pulses; busy=0, wiper=0.
- From wiper=0, load target=5: dp_ud=1, exactly 5 INC pulses, wiper=5, done once. Total load-to-done time is 1+2+40+2+1=46 cycles.
- From wiper=5, load target=2: dp_ud=0, exactly 3 pulses, wiper=2; dp_cs_n stays low across the whole burst.
- Load target=2 when wiper=2: done next cycle; dp_cs_n and dp_inc_n never toggle. Load target=100: err for one cycle, no activity, wiper unchanged.
- During a 50-step move, pulse load target=10 and home: both are ignored, and the move completes at 50.
- Assert reset after 20 pulses of a move: dp_cs_n=1 and dp_inc_n=1 in the same cycle. After release, a full 100-pulse home runs and ends with wiper=0.
